ahb_lite_arb2: RTL
==================

Name: ahb_lite_arb2

Overview:
- Two-master to one-slave AHB-Lite arbiter.
- Shares the downstream system AHB-Lite bus (memories, peripherals) between the Cortex-M0 integration master port (m0) and a second master (m1, DMA/test loader).
- AHB-Lite masters have no bus-request signal, so each input port has a one-deep address-phase holding register. A losing master is stalled through its HREADYOUT until its transfer has been forwarded and completed.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR, 0, 0 = fixed priority (m0 highest); 1 = round-robin (last data-phase owner loses ties)

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  synchronous active-low reset
- mX_haddr  in  ADDR_W  master X address (X = 0, 1; each master has the full set below)
- mX_htrans  in  2  transfer type
- mX_hwrite  in  1  write
- mX_hsize  in  3  size
- mX_hburst  in  3  burst
- mX_hprot  in  4  protection
- mX_hmastlock  in  1  locked transfer
- mX_hwdata  in  DATA_W  write data
- mX_hrdata  out  DATA_W  read data
- mX_hreadyout  out  1  ready to master X
- mX_hresp  out  1  response to master X
- s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock, s_hwdata  out  (widths as above)  slave-side bus
- s_hmaster  out  1  owner of the current address phase
- s_hrdata  in  DATA_W  slave read data
- s_hready  in  1  slave-side HREADY
- s_hresp  in  1  slave response

Behaviour:
- **Reset** (HRESETn low at a HCLK edge): pending registers cleared; no grant; data-phase owner invalid; grant history = m1.
  - Outputs while reset is held: s_htrans=IDLE; s_haddr=0; s_hmastlock=0; s_hmaster=0; mX_hreadyout=1; mX_hresp=OKAY.
  - Reset mid-transfer drops all in-flight state; no completion is reported.
- **Request**: master X requests when its pending register is valid, or when the live mX_htrans is NONSEQ/SEQ and mX_hreadyout=1.
- **Capture**: a live request sampled with mX_hreadyout=1 that is not forwarded that cycle is stored in pend_X (addr + all control) at the edge.
  - The pending register is one deep.
  - The master is stalled (hreadyout=0), so no second capture can occur while pend_X is valid.
- **Arbitration** is evaluated every cycle; the grant takes effect at the edge where s_hready=1.
- **Grant hold**: the current owner keeps the grant while its forwarded transfer had hmastlock=1, or while it presents SEQ/BUSY. Bursts and locked sequences are never split.
- **Winner selection** otherwise: the sole requester wins. If both request, RR=0 selects m0; RR=1 selects the master that was not the last winner.
- **Address mux**: the granted master drives the s_ address/control signals, from pend_X if valid, else live inputs. s_hmaster = granted index.
  - With no request: s_htrans=IDLE, s_hmastlock=0, other address/control = last values.
- **Data-phase tracking**: at an edge with s_hready=1, dp_owner/dp_valid take the index of the forwarded transfer; dp_valid=0 if the forwarded transfer was IDLE/BUSY.
  - pend_X clears at the edge its contents are forwarded with s_hready=1.
- **Data mux**: s_hwdata = mX_hwdata of dp_owner, or 0 if dp_valid=0. s_hrdata is broadcast to both mX_hrdata.
- **mX_hreadyout**, in priority order:
  - s_hready, if X is the valid data-phase owner;
  - else 0, if pend_X is valid;
  - else 1.
- **mX_hresp**: s_hresp if X is the data-phase owner, else OKAY. The two-cycle ERROR passes through unchanged. A master cancelling with IDLE after ERROR is handled as a normal non-request.
- **Latency**:
  - An uncontended transfer adds zero cycles (combinational live path).
  - A contended transfer waits in pend_X until granted, then pays one slave data phase.

Test Plan:
- m0 alone: NONSEQ read 0x0000_0100, slave zero-wait, s_hrdata=0xCAFEBABE → s_ bus shows addr the same cycle; m0 gets 0xCAFEBABE and hreadyout=1 next cycle; s_hmaster=0.
- Simultaneous NONSEQ writes: m0 to 0x2000_0000 data 0x11, m1 to 0x2000_0004 data 0x22, RR=0 → m0 is forwarded first; m1 is captured in pend_1 with m1_hreadyout=0. m1's phase goes out next; slave sees 0x11 then 0x22 at the correct addresses.
- RR=1, both masters issuing back-to-back single transfers for 8 cycles → grants alternate 0,1,0,1…; neither master is starved.
- m1 INCR4 burst (NONSEQ+3 SEQ) while m0 requests mid-burst → all 4 beats go out uninterrupted; m0 is granted after the final beat. Same check with m0 hmastlock=1 over 2 transfers: m1 is blocked until the lock drops.
- Slave inserts 2 wait states then a two-cycle ERROR on an m1 transfer → only m1 sees hreadyout=0, 0, 0, 1 with hresp=1 on the last two cycles; m0_hresp stays 0.
- Assert HRESETn=0 for one cycle while pend_1 is valid and a data phase is in flight → next cycle: both hreadyout=1, s_htrans=IDLE, no stale transfer is forwarded.

Source files
------------

// File: rtl/ahb_lite_arb2.sv
// ahb_lite_arb2: shares one AHB-Lite slave bus between two masters. Each master
// port has a one-deep address-phase holding register; a losing master is stalled.
module ahb_lite_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [3:0]        m0_hprot,
    input  logic              m0_hmastlock,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hreadyout,
    output logic              m0_hresp,

    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [3:0]        m1_hprot,
    input  logic              m1_hmastlock,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hreadyout,
    output logic              m1_hresp,

    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic [3:0]        s_hprot,
    output logic              s_hmastlock,
    output logic [DATA_W-1:0] s_hwdata,
    output logic              s_hmaster,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        trans;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              lock;
    } ctrl_t;

    ctrl_t      live [2];
    ctrl_t      pend [2];
    ctrl_t      last_ctrl;
    ctrl_t      fwd;
    logic [1:0] pend_valid;
    logic [1:0] ready;
    logic [1:0] live_req;
    logic [1:0] req;
    logic [1:0] capture;
    logic       addr_owner;
    logic       addr_owner_valid;
    logic       addr_lock;
    logic       last_winner;
    logic       dp_owner;
    logic       dp_valid;
    logic       hold;
    logic       grant;
    logic       sel_valid;
    logic       fwd_en;

    assign live[0] = {m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock};
    assign live[1] = {m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock};

    // A pending master is never the data-phase owner, so it always sees a stall.
    assign ready[0] = (dp_valid && !dp_owner) ? s_hready : !pend_valid[0];
    assign ready[1] = (dp_valid &&  dp_owner) ? s_hready : !pend_valid[1];

    assign live_req[0] = live[0].trans[1] && ready[0];
    assign live_req[1] = live[1].trans[1] && ready[1];
    assign req         = pend_valid | live_req;

    // SEQ and BUSY both have trans[0] set, so one bit keeps a burst together.
    always_comb begin
        hold      = addr_owner_valid && (addr_lock || live[addr_owner].trans[0]);
        grant     = addr_owner;
        if (hold) begin
            grant = addr_owner;
        end else if (req[0] && req[1]) begin
            grant = (RR != 0) ? ~last_winner : 1'b0;
        end else if (req[1]) begin
            grant = 1'b1;
        end else if (req[0]) begin
            grant = 1'b0;
        end
        sel_valid = hold || (req != 2'b00);
    end

    always_comb begin
        fwd = last_ctrl;
        if (!sel_valid) begin
            fwd.trans = HTRANS_IDLE;
            fwd.lock  = 1'b0;
        end else if (pend_valid[grant]) begin
            fwd = pend[grant];
        end else begin
            fwd = live[grant];
            if (!ready[grant]) begin
                fwd.trans = HTRANS_IDLE;
            end
        end
    end

    assign fwd_en     = s_hready && sel_valid;
    assign capture[0] = live_req[0] && !(fwd_en && !grant);
    assign capture[1] = live_req[1] && !(fwd_en &&  grant);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_valid       <= 2'b00;
            pend[0]          <= '0;
            pend[1]          <= '0;
            last_ctrl        <= '0;
            addr_owner       <= 1'b0;
            addr_owner_valid <= 1'b0;
            addr_lock        <= 1'b0;
            last_winner      <= 1'b1;
            dp_owner         <= 1'b0;
            dp_valid         <= 1'b0;
        end else begin
            if (capture[0]) begin
                pend_valid[0] <= 1'b1;
                pend[0]       <= live[0];
            end else if (fwd_en && !grant) begin
                pend_valid[0] <= 1'b0;
            end
            if (capture[1]) begin
                pend_valid[1] <= 1'b1;
                pend[1]       <= live[1];
            end else if (fwd_en && grant) begin
                pend_valid[1] <= 1'b0;
            end
            if (sel_valid) begin
                last_ctrl <= fwd;
            end
            if (s_hready) begin
                dp_valid  <= sel_valid && fwd.trans[1];
                dp_owner  <= grant;
                addr_lock <= sel_valid && fwd.lock;
                if (sel_valid) begin
                    addr_owner       <= grant;
                    addr_owner_valid <= 1'b1;
                end
                if (sel_valid && fwd.trans[1]) begin
                    last_winner <= grant;
                end
            end
        end
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // Reset is synchronous, so hold the bus quiet combinationally while it is low.
    always_comb begin
        s_haddr      = fwd.addr;
        s_htrans     = fwd.trans;
        s_hwrite     = fwd.write;
        s_hsize      = fwd.size;
        s_hburst     = fwd.burst;
        s_hprot      = fwd.prot;
        s_hmastlock  = fwd.lock;
        s_hmaster    = grant;
        s_hwdata     = !dp_valid ? '0 : (dp_owner ? m1_hwdata : m0_hwdata);
        m0_hreadyout = ready[0];
        m1_hreadyout = ready[1];
        m0_hresp     = (dp_valid && !dp_owner) ? s_hresp : 1'b0;
        m1_hresp     = (dp_valid &&  dp_owner) ? s_hresp : 1'b0;
        if (!HRESETn) begin
            s_haddr      = '0;
            s_htrans     = HTRANS_IDLE;
            s_hmastlock  = 1'b0;
            s_hmaster    = 1'b0;
            s_hwdata     = '0;
            m0_hreadyout = 1'b1;
            m1_hreadyout = 1'b1;
            m0_hresp     = 1'b0;
            m1_hresp     = 1'b0;
        end
    end

endmodule
